// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, ALUOp encodings and the decoder control bundle.
package pipe_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;

  typedef enum logic [1:0] {
    AluRtype = 2'b00,
    AluAdd   = 2'b01,
    AluBeq   = 2'b10,
    AluBne   = 2'b11
  } aluop_e;

  typedef struct packed {
    aluop_e aluop;
    logic   alusrc;
    logic   regwrite;
    logic   regdst;
    logic   branch;
    logic   memread;
    logic   memwrite;
    logic   memtoreg;
  } ctrl_t;

  localparam int unsigned CtrlW = $bits(ctrl_t);

  localparam ctrl_t CtrlBubble = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load in EX and the instruction in ID.
module load_use_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              hazard
);

  logic rs_match;
  logic rt_match;
  logic load_live;

  // $0 never carries a produced value, so a load into it cannot create a dependency.
  assign load_live = ex_valid & ex_memread & (ex_rt != '0);
  assign rs_match  = (ex_rt == id_rs);
  assign rt_match  = id_uses_rt & (ex_rt == id_rt);
  assign hazard    = load_live & (rs_match | rt_match) & id_valid;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall and branch-flush bubble injection.
// Define ID_EX_STATS_EN to add saturating stall/flush statistics counters.
module id_ex_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [1:0]        id_aluop_i,
  input  logic              id_alusrc_i,
  input  logic              id_regwrite_i,
  input  logic              id_regdst_i,
  input  logic              id_branch_i,
  input  logic              id_memread_i,
  input  logic              id_memwrite_i,
  input  logic              id_memtoreg_i,
  input  logic [DATA_W-1:0] id_pc4_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [5:0]        id_funct_i,
  input  logic              flush_i,
`ifdef ID_EX_STATS_EN
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
`endif
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [1:0]        ex_aluop_o,
  output logic              ex_alusrc_o,
  output logic              ex_regwrite_o,
  output logic              ex_regdst_o,
  output logic              ex_branch_o,
  output logic              ex_memread_o,
  output logic              ex_memwrite_o,
  output logic              ex_memtoreg_o,
  output logic [DATA_W-1:0] ex_pc4_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [REG_AW-1:0] ex_rs_o,
  output logic [REG_AW-1:0] ex_rt_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [5:0]        ex_funct_o
);

  ctrl_t             id_ctrl;
  ctrl_t             ctrl_q;
  logic              valid_q;
  logic [DATA_W-1:0] pc4_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] rd_q;
  logic [5:0]        funct_q;

  logic uses_rt;
  logic hazard;
  logic capture;

  assign id_ctrl = '{
    aluop:    aluop_e'(id_aluop_i),
    alusrc:   id_alusrc_i,
    regwrite: id_regwrite_i,
    regdst:   id_regdst_i,
    branch:   id_branch_i,
    memread:  id_memread_i,
    memwrite: id_memwrite_i,
    memtoreg: id_memtoreg_i
  };

  // rt is a source for R-type, branches and sw; for addi/lw it is the destination.
  assign uses_rt = ~id_alusrc_i | id_memwrite_i;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_load_use_detect (
    .ex_valid  (valid_q),
    .ex_memread(ctrl_q.memread),
    .ex_rt     (rt_q),
    .id_valid  (id_valid_i),
    .id_rs     (id_rs_i),
    .id_rt     (id_rt_i),
    .id_uses_rt(uses_rt),
    .hazard    (hazard)
  );

  // A flushed ID instruction is discarded anyway, so it must not hold the front end.
  assign stall_o = hazard & ~flush_i;
  assign capture = id_valid_i & ~flush_i & ~hazard;

  // Reset and bubbles share one all-zero state so a bubble is fully deterministic.
  always_ff @(posedge clk_i) begin
    if (rst_i || !capture) begin
      valid_q   <= 1'b0;
      ctrl_q    <= CtrlBubble;
      pc4_q     <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      funct_q   <= '0;
    end else begin
      valid_q   <= 1'b1;
      ctrl_q    <= id_ctrl;
      pc4_q     <= id_pc4_i;
      rs_data_q <= id_rs_data_i;
      rt_data_q <= id_rt_data_i;
      imm_q     <= id_imm_i;
      rs_q      <= id_rs_i;
      rt_q      <= id_rt_i;
      rd_q      <= id_rd_i;
      funct_q   <= id_funct_i;
    end
  end

  assign ex_valid_o    = valid_q;
  assign ex_aluop_o    = ctrl_q.aluop;
  assign ex_alusrc_o   = ctrl_q.alusrc;
  assign ex_regwrite_o = ctrl_q.regwrite;
  assign ex_regdst_o   = ctrl_q.regdst;
  assign ex_branch_o   = ctrl_q.branch;
  assign ex_memread_o  = ctrl_q.memread;
  assign ex_memwrite_o = ctrl_q.memwrite;
  assign ex_memtoreg_o = ctrl_q.memtoreg;
  assign ex_pc4_o      = pc4_q;
  assign ex_rs_data_o  = rs_data_q;
  assign ex_rt_data_o  = rt_data_q;
  assign ex_imm_o      = imm_q;
  assign ex_rs_o       = rs_q;
  assign ex_rt_o       = rt_q;
  assign ex_rd_o       = rd_q;
  assign ex_funct_o    = funct_q;

`ifdef ID_EX_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_o && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_i && !(&flush_cnt_q)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  // CNT_W only sizes the statistics counters, which this build leaves out.
  if (CNT_W == 0) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: directed MIPS sequences then random traffic.
module tb_id_ex_stage_reg;

  localparam int unsigned CntW = 4;
  localparam int CntMax = (1 << CntW) - 1;

  localparam int KR    = 0;
  localparam int KAddi = 1;
  localparam int KLw   = 2;
  localparam int KSw   = 3;
  localparam int KBeq  = 4;
  localparam int KBne  = 5;

  typedef struct packed {
    logic        valid;
    logic [1:0]  aluop;
    logic        alusrc;
    logic        regwrite;
    logic        regdst;
    logic        branch;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic [31:0] pc4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
  } stage_t;

  typedef struct {
    stage_t          exp;
    logic            chk_stall;
    logic            exp_stall;
    logic [CntW-1:0] exp_scnt;
    logic [CntW-1:0] exp_fcnt;
    string           tag;
  } rec_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   flush = 1'b0;
  stage_t id_in = '0;
  stage_t ex_got;

  logic        stall, ex_valid, ex_alusrc, ex_regwrite, ex_regdst, ex_branch;
  logic        ex_memread, ex_memwrite, ex_memtoreg;
  logic [1:0]  ex_aluop;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [5:0]  ex_funct;
  logic [CntW-1:0] scnt, fcnt;

  int total = 0;
  int bad   = 0;

  rec_t   q[$];
  rec_t   mon_e;
  logic   got_stall;

  // Reference state: what EX should hold after each edge.
  stage_t mstate = '0;
  logic   mknown = 1'b0;
  int     mscnt = 0;
  int     mfcnt = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(
    .DATA_W(32),
    .REG_AW(5),
    .CNT_W (CntW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .id_valid_i   (id_in.valid),
    .id_aluop_i   (id_in.aluop),
    .id_alusrc_i  (id_in.alusrc),
    .id_regwrite_i(id_in.regwrite),
    .id_regdst_i  (id_in.regdst),
    .id_branch_i  (id_in.branch),
    .id_memread_i (id_in.memread),
    .id_memwrite_i(id_in.memwrite),
    .id_memtoreg_i(id_in.memtoreg),
    .id_pc4_i     (id_in.pc4),
    .id_rs_data_i (id_in.rs_data),
    .id_rt_data_i (id_in.rt_data),
    .id_imm_i     (id_in.imm),
    .id_rs_i      (id_in.rs),
    .id_rt_i      (id_in.rt),
    .id_rd_i      (id_in.rd),
    .id_funct_i   (id_in.funct),
    .flush_i      (flush),
`ifdef ID_EX_STATS_EN
    .stall_cnt_o  (scnt),
    .flush_cnt_o  (fcnt),
`endif
    .stall_o      (stall),
    .ex_valid_o   (ex_valid),
    .ex_aluop_o   (ex_aluop),
    .ex_alusrc_o  (ex_alusrc),
    .ex_regwrite_o(ex_regwrite),
    .ex_regdst_o  (ex_regdst),
    .ex_branch_o  (ex_branch),
    .ex_memread_o (ex_memread),
    .ex_memwrite_o(ex_memwrite),
    .ex_memtoreg_o(ex_memtoreg),
    .ex_pc4_o     (ex_pc4),
    .ex_rs_data_o (ex_rs_data),
    .ex_rt_data_o (ex_rt_data),
    .ex_imm_o     (ex_imm),
    .ex_rs_o      (ex_rs),
    .ex_rt_o      (ex_rt),
    .ex_rd_o      (ex_rd),
    .ex_funct_o   (ex_funct)
  );

`ifndef ID_EX_STATS_EN
  assign scnt = '0;
  assign fcnt = '0;
`endif

  assign ex_got = '{
    valid: ex_valid, aluop: ex_aluop, alusrc: ex_alusrc, regwrite: ex_regwrite,
    regdst: ex_regdst, branch: ex_branch, memread: ex_memread, memwrite: ex_memwrite,
    memtoreg: ex_memtoreg, pc4: ex_pc4, rs_data: ex_rs_data, rt_data: ex_rt_data,
    imm: ex_imm, rs: ex_rs, rt: ex_rt, rd: ex_rd, funct: ex_funct
  };

  // What a MIPS main decoder produces for each instruction kind.
  function automatic stage_t mk(input int kind, input int rs, input int rt, input int rd,
                                input logic [31:0] imm);
    stage_t s;
    s = '0;
    s.valid   = 1'b1;
    s.rs      = rs[4:0];
    s.rt      = rt[4:0];
    s.rd      = rd[4:0];
    s.imm     = imm;
    s.funct   = imm[5:0];
    s.pc4     = $urandom;
    s.rs_data = $urandom;
    s.rt_data = $urandom;
    case (kind)
      KR:      begin s.aluop = 2'b00; s.regwrite = 1'b1; s.regdst = 1'b1; s.funct = 6'h20; end
      KAddi:   begin s.aluop = 2'b01; s.alusrc = 1'b1; s.regwrite = 1'b1; end
      KLw:     begin
        s.aluop = 2'b01; s.alusrc = 1'b1; s.regwrite = 1'b1; s.memread = 1'b1; s.memtoreg = 1'b1;
      end
      KSw:     begin s.aluop = 2'b01; s.alusrc = 1'b1; s.memwrite = 1'b1; end
      KBeq:    begin s.aluop = 2'b10; s.branch = 1'b1; end
      default: begin s.aluop = 2'b11; s.branch = 1'b1; end
    endcase
    return s;
  endfunction

  function automatic stage_t rand_instr();
    return mk($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), 32'($urandom_range(0, 255)));
  endfunction

  // One clock of stimulus; the model decides stall and the post-edge EX contents.
  task automatic cyc(input stage_t in, input logic fl, input logic r, input string tag,
                     output logic st);
    rec_t e;
    logic reads_load;
    logic hz;
    @(negedge clk);
    id_in = in;
    flush = fl;
    rst   = r;
    reads_load = (mstate.rt == in.rs) || ((!in.alusrc || in.memwrite) && mstate.rt == in.rt);
    hz = mstate.valid && mstate.memread && (mstate.rt != 5'd0) && in.valid && reads_load;
    st = hz && !fl;
    e.chk_stall = mknown;
    e.exp_stall = st;
    e.tag = tag;
    if (r || fl || hz || !in.valid) begin
      mstate = '0;
    end else begin
      mstate = in;
      mstate.valid = 1'b1;
    end
    if (r) begin
      mscnt = 0;
      mfcnt = 0;
    end else begin
      if (st && mknown && mscnt < CntMax) mscnt++;
      if (fl && mfcnt < CntMax) mfcnt++;
    end
    mknown = mknown || r;
    e.exp = mstate;
    e.exp_scnt = CntW'(mscnt);
    e.exp_fcnt = CntW'(mfcnt);
    q.push_back(e);
  endtask

  // Issue an instruction from ID, re-presenting it while the model says the front end stalls.
  task automatic issue(input stage_t in, input string tag);
    logic st;
    for (int k = 0; k < 3; k++) begin
      cyc(in, 1'b0, 1'b0, tag, st);
      if (!st) break;
    end
  endtask

  // Monitor: stall sampled late in the cycle, EX state sampled just after the edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      got_stall = stall;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        total++;
        if (ex_got !== mon_e.exp) begin
          bad++;
          $display("FAIL %s ex_state: got %h want %h", mon_e.tag, ex_got, mon_e.exp);
        end
        if (mon_e.chk_stall) begin
          total++;
          if (got_stall !== mon_e.exp_stall) begin
            bad++;
            $display("FAIL %s stall_o: got %b want %b", mon_e.tag, got_stall, mon_e.exp_stall);
          end
        end
`ifdef ID_EX_STATS_EN
        total++;
        if (scnt !== mon_e.exp_scnt || fcnt !== mon_e.exp_fcnt) begin
          bad++;
          $display("FAIL %s counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                   mon_e.tag, scnt, fcnt, mon_e.exp_scnt, mon_e.exp_fcnt);
        end
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stage_t idle;
    stage_t cur;
    logic   st;
    idle = '0;

    cyc(rand_instr(), 1'($urandom_range(0, 1)), 1'b1, "reset", st);
    cyc(rand_instr(), 1'($urandom_range(0, 1)), 1'b1, "reset", st);
    issue(mk(KAddi, 0, 1, 0, 32'd5), "addi_after_reset");
    issue(idle, "idle");

    issue(mk(KLw, 0, 2, 0, 32'd0), "loaduse_lw");
    issue(mk(KR, 2, 4, 3, 32'd0), "loaduse_add");
    issue(idle, "idle");

    issue(mk(KLw, 0, 2, 0, 32'd0), "imm_rt_lw");
    issue(mk(KAddi, 5, 2, 0, 32'd1), "imm_rt_addi");
    issue(mk(KLw, 0, 0, 0, 32'd0), "zero_lw");
    issue(mk(KR, 0, 0, 3, 32'd0), "zero_add");

    issue(mk(KLw, 0, 2, 0, 32'd0), "flush_lw");
    cyc(mk(KSw, 0, 2, 0, 32'd4), 1'b1, 1'b0, "flush_vs_hazard", st);
    issue(idle, "idle");

    issue(mk(KLw, 0, 2, 0, 32'd0), "b2b_lw2");
    issue(mk(KLw, 2, 3, 0, 32'd0), "b2b_lw3");
    issue(mk(KR, 3, 3, 4, 32'd0), "b2b_add");

    issue(mk(KLw, 0, 2, 0, 32'd0), "rst_stall_lw");
    cyc(mk(KR, 2, 1, 5, 32'd0), 1'b0, 1'b1, "rst_during_stall", st);
    issue(mk(KR, 2, 1, 5, 32'd0), "after_rst");

    // Three load-use stalls and two flushes for the statistics path.
    for (int i = 0; i < 3; i++) begin
      issue(mk(KLw, 0, 3, 0, 32'd8), "stats_lw");
      issue(mk(KBeq, 1, 3, 0, 32'd2), "stats_beq");
    end
    cyc(rand_instr(), 1'b1, 1'b0, "stats_flush", st);
    cyc(rand_instr(), 1'b1, 1'b0, "stats_flush", st);

    st = 1'b0;
    cur = idle;
    for (int i = 0; i < 3000; i++) begin
      logic fl;
      logic r;
      if (!st) begin
        cur = rand_instr();
        cur.valid = ($urandom_range(0, 9) != 0);
      end
      fl = ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 399) == 0);
      cyc(cur, fl, r, "random", st);
    end
    issue(idle, "drain");

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register for the pipelined MIPS core.
- Sits directly downstream of the main instruction decoder and captures its control bundle plus the ID-stage operands each cycle.
- Contains load-use hazard detection: on a hazard it stalls PC and IF/ID for one cycle and injects a bubble into EX.
- Honours a branch flush from the branch-resolution logic by injecting a bubble.

Parameters:
- DATA_W, 32, width of the PC+4, register operand and immediate datapaths
- REG_AW, 5, register-specifier width
- CNT_W, 16, width of the optional statistics counters

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous active-high reset
- id_valid_i  in  1  ID holds a real instruction
- id_aluop_i  in  2  decoder ALUOp
- id_alusrc_i, id_regwrite_i, id_regdst_i, id_branch_i, id_memread_i, id_memwrite_i, id_memtoreg_i  in  1 each  decoder controls
- id_pc4_i  in  DATA_W  PC+4 of the ID instruction
- id_rs_data_i, id_rt_data_i  in  DATA_W  register-file read data
- id_imm_i  in  DATA_W  sign-extended immediate
- id_rs_i, id_rt_i, id_rd_i  in  REG_AW  register specifiers
- id_funct_i  in  6  funct field
- flush_i  in  1  branch taken: ID contents are wrong-path
- stall_o  out  1  hold PC and IF/ID this cycle
- ex_valid_o  out  1  EX holds a real instruction
- ex_aluop_o, ex_alusrc_o … ex_memtoreg_o  out  same widths as the inputs  registered controls
- ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o  out  DATA_W  registered data
- ex_rs_o, ex_rt_o, ex_rd_o  out  REG_AW; ex_funct_o  out  6

Behaviour:
- Reset: every ex_* output is 0 and ex_valid_o = 0 on the first edge with rst_i = 1. stall_o = 0 from then on, because it is derived from the reset registers.
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Hazard detection (combinational): hazard = ex_valid_o & ex_memread_o & (ex_rt_o != 0) & (ex_rt_o == id_rs_i | (uses_rt & ex_rt_o == id_rt_i)) & id_valid_i.
- uses_rt = !id_alusrc_i | id_memwrite_i. This covers R-type, beq, bne and sw.
- stall_o = hazard & !flush_i.
- Register update priority, evaluated each edge:
  1. rst_i = 1: all registers cleared.
  2. flush_i = 1: bubble.
  3. hazard = 1: bubble.
  4. id_valid_i = 0: bubble.
  5. Otherwise: capture all ID inputs and set ex_valid_o = 1.
- A bubble sets all control outputs and ex_valid_o to 0 and sets data and specifier outputs to 0, so the bubble is deterministic.
- Stall length is exactly one cycle. After the bubble, ex_memread_o = 0, so the hazard clears and the held instruction is captured on the next edge.
- Back-to-back lw with a dependent third instruction: each dependent pair stalls exactly once.
- Simultaneous flush and hazard: flush wins, stall_o = 0, and the wrong-path instruction is discarded.
- Reset during a stall: the registers clear and stall_o drops in the same cycle the reset edge is taken.

Optional Feature:
- Macro: ID_EX_STATS_EN.
- When defined:
  - Adds output ports stall_cnt_o and flush_cnt_o, each CNT_W bits.
  - stall_cnt_o increments on each edge where stall_o = 1.
  - flush_cnt_o increments on each edge where flush_i = 1.
  - Both counters saturate at all-ones and clear on rst_i.
- When undefined: the ports and the counters do not exist, and all other behaviour is unchanged.

Decomposition:
- Shared package pipe_pkg holds:
  - opcode constants: R-type 000000, addi 001000, lw, sw, beq, bne
  - ALUOp encodings: 00 R-type, 01 add, 10 beq, 11 bne
  - the control-bundle width and a packed control-bundle typedef
  - the bubble (all-zero) control constant
- One sub-module, load_use_detect, purely combinational. It takes the EX memread/rt/valid signals and the ID rs/rt/uses_rt/valid signals, and produces hazard.

Test Plan:
- Reset: hold rst_i for 2 cycles with random inputs. Required: every ex_* output is 0, stall_o = 0. Then an addi $1,$0,5 in ID gives ex_valid_o = 1, ex_aluop_o = 01, ex_alusrc_o = 1, ex_imm_o = 5 one cycle later.
- Load-use: lw $2,0($0) followed by add $3,$2,$4. Required: stall_o = 1 for exactly one cycle, EX bubble (ex_valid_o = 0), then the add captured with ex_rs_o = 2.
- No false stall on immediate rt:
  - lw $2 followed by addi $2,$5,1 (rt = 2 is a destination): stall_o = 0.
  - lw $0 followed by add $3,$0,$0: stall_o = 0.
- Flush vs hazard: lw $2 in EX, dependent sw in ID, flush_i = 1 in the same cycle. Required: stall_o = 0, EX bubble, and no capture of the sw.
- Back-to-back loads: lw $2, lw $3,0($2), add $4,$3,$3. Required: two separate single-cycle stalls, and the final add appears in EX with ex_rs_data_o equal to the value driven at capture.
- ID_EX_STATS_EN: drive 3 load-use stalls and 2 flushes. Required: stall_cnt_o = 3, flush_cnt_o = 2. With CNT_W = 2, 5 stalls saturate the counter at 3.
